// File: rtl/delay_line_pkg.sv
// Shared types, default sizes and the delay clamp helper for the variable delay line.
package delay_line_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_MAX_DELAY = 15;
  localparam int unsigned DEF_DLY_W     = 5;

  // Limit a requested delay to the largest selectable tap.
  function automatic int unsigned clamp_delay(input int unsigned d, input int unsigned max_d);
    return (d > max_d) ? max_d : d;
  endfunction

endpackage

// File: rtl/delay_line_ctrl.sv
// Delay controller: active delay register, settle FSM/counter and clamp error pulse.
module delay_line_ctrl
  import delay_line_pkg::*;
#(
  parameter int unsigned MAX_DELAY = DEF_MAX_DELAY,
  parameter int unsigned DLY_W     = DEF_DLY_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DLY_W-1:0] delay_i,
  output logic [DLY_W-1:0] dly_q,
  output logic             settle_mask,
  output logic             cfg_err_o
);

  localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DELAY);

  state_t           state_q;
  logic [DLY_W-1:0] cnt_q;
  logic [DLY_W-1:0] dnew;
  logic [DLY_W-1:0] cnt_ld;
  logic             change;
  logic             over;

  // Change detection; the mask covers the change edge itself plus the remaining settle cycles.
  always_comb begin
    over        = 1'b0;
    dnew        = '0;
    change      = 1'b0;
    cnt_ld      = '0;
    settle_mask = 1'b0;
    over        = (delay_i > MAX_D);
    dnew        = DLY_W'(clamp_delay(32'(delay_i), MAX_DELAY));
    change      = (dnew != dly_q);
    cnt_ld      = (dnew == '0) ? '0 : DLY_W'(dnew - DLY_W'(1));
    settle_mask = change | ((state_q == SETTLE) && (cnt_q != '0));
  end

  // Settle FSM: a change reloads the counter, RUN resumes once it has drained.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= RUN;
      dly_q     <= '0;
      cnt_q     <= '0;
      cfg_err_o <= 1'b0;
    end else begin
      cfg_err_o <= change & over;
      if (change) begin
        dly_q   <= dnew;
        cnt_q   <= cnt_ld;
        state_q <= SETTLE;
      end else begin
        case (state_q)
          SETTLE: begin
            if (cnt_q == '0) state_q <= RUN;
            else             cnt_q   <= DLY_W'(cnt_q - DLY_W'(1));
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

endmodule

// File: rtl/delay_line_var.sv
// Variable-latency delay line: shift register, tap mux and registered outputs.
module delay_line_var
  import delay_line_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned MAX_DELAY = DEF_MAX_DELAY,
  parameter int unsigned DLY_W     = DEF_DLY_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  input  logic [DLY_W-1:0] delay_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             settling_o,
  output logic             cfg_err_o
);

  logic [WIDTH-1:0]     sr_data [MAX_DELAY];
  logic [MAX_DELAY-1:0] sr_valid;
  logic [DLY_W-1:0]     dly_q;
  logic                 settle_mask;
  logic [WIDTH-1:0]     tap_data;
  logic                 tap_valid;

  delay_line_ctrl #(
    .MAX_DELAY (MAX_DELAY),
    .DLY_W     (DLY_W)
  ) u_ctrl (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .delay_i     (delay_i),
    .dly_q       (dly_q),
    .settle_mask (settle_mask),
    .cfg_err_o   (cfg_err_o)
  );

  // Free-running shift register; entry k holds the sample from k+1 cycles ago.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int unsigned k = 0; k < MAX_DELAY; k++) sr_data[k] <= '0;
      sr_valid <= '0;
    end else begin
      sr_data[0]  <= data_i;
      sr_valid[0] <= valid_i;
      for (int unsigned k = 1; k < MAX_DELAY; k++) begin
        sr_data[k]  <= sr_data[k-1];
        sr_valid[k] <= sr_valid[k-1];
      end
    end
  end

  // Tap select: zero delay bypasses the register chain.
  always_comb begin
    tap_data  = data_i;
    tap_valid = valid_i;
    for (int unsigned k = 0; k < MAX_DELAY; k++) begin
      if (dly_q == DLY_W'(k + 1)) begin
        tap_data  = sr_data[k];
        tap_valid = sr_valid[k];
      end
    end
  end

  // Output registers; data passes through while valid is masked during settle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      data_o     <= '0;
      valid_o    <= 1'b0;
      settling_o <= 1'b0;
    end else begin
      data_o     <= tap_data;
      valid_o    <= tap_valid & ~settle_mask;
      settling_o <= settle_mask;
    end
  end

endmodule

// File: tb/tb_delay_line_var.sv
// Directed bench for delay_line_var: vector table plus hand-written settle/reset sequences.
module tb_delay_line_var;
  import delay_line_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] data_i = '0;
  logic       valid_i = 1'b0;
  logic [4:0] delay_i = '0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       settling_o;
  logic       cfg_err_o;

  int n_assert = 0;
  int n_fail   = 0;

  delay_line_var dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .delay_i    (delay_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .settling_o (settling_o),
    .cfg_err_o  (cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0] dly;
    logic       v;
    logic [7:0] d;
    logic       exp_v;
    logic       exp_s;
    logic       chk_d;
    logic [7:0] exp_d;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs away from the edge, take one rising edge, then settle 1 time unit.
  task automatic tick(input logic [4:0] dl, input logic v, input logic [7:0] d);
    delay_i = dl;
    valid_i = v;
    data_i  = d;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // d=0 after d=14, then the 1,0,1,1 valid-hole pattern at d=3.
    tbl[0]  = '{5'd0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{5'd0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A};
    tbl[2]  = '{5'd0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 8'h33};
    tbl[3]  = '{5'd0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3};
    tbl[4]  = '{5'd3, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{5'd3, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[6]  = '{5'd3, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[7]  = '{5'd3, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h11};
    tbl[8]  = '{5'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22};
    tbl[9]  = '{5'd3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33};
    tbl[10] = '{5'd3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44};
    tbl[11] = '{5'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};

    // Reset state.
    rst_i = 1'b0;
    repeat (3) tick(5'd14, 1'b1, 8'h77);
    check("rst_data", 32'(data_o), 32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_settling", 32'(settling_o), 32'h0);
    check("rst_cfg_err", 32'(cfg_err_o), 32'h0);
    check("rst_dly_q", 32'(dut.u_ctrl.dly_q), 32'h0);

    // Release with d=14 and stream 0xA0.. from E0.
    rst_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(5'd14, 1'b1, 8'(8'hA0 + k));
      if (k < 14) begin
        check($sformatf("d14_mask_v_%0d", k), 32'(valid_o), 32'h0);
        check($sformatf("d14_mask_s_%0d", k), 32'(settling_o), 32'h1);
      end else begin
        check($sformatf("d14_valid_%0d", k), 32'(valid_o), 32'h1);
        check($sformatf("d14_data_%0d", k), 32'(data_o), 32'(8'hA0 + (k - 14)));
        check($sformatf("d14_settle_%0d", k), 32'(settling_o), 32'h0);
      end
    end
    check("d14_dly_q", 32'(dut.u_ctrl.dly_q), 32'd14);

    // Table vectors.
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].dly, tbl[i].v, tbl[i].d);
      check($sformatf("tbl_valid_%0d", i), 32'(valid_o), 32'(tbl[i].exp_v));
      check($sformatf("tbl_settle_%0d", i), 32'(settling_o), 32'(tbl[i].exp_s));
      if (tbl[i].chk_d) check($sformatf("tbl_data_%0d", i), 32'(data_o), 32'(tbl[i].exp_d));
    end

    // Stream at d=3, then change to 7 at G0.
    for (int k = 0; k < 5; k++) begin
      tick(5'd3, 1'b1, 8'(8'h60 + k));
      if (k >= 3) begin
        check($sformatf("d3_valid_%0d", k), 32'(valid_o), 32'h1);
        check($sformatf("d3_data_%0d", k), 32'(data_o), 32'(8'h60 + (k - 3)));
      end
    end
    for (int k = 0; k < 11; k++) begin
      tick(5'd7, 1'b1, 8'(8'h65 + k));
      if (k < 7) begin
        check($sformatf("d7_mask_v_%0d", k), 32'(valid_o), 32'h0);
        check($sformatf("d7_mask_s_%0d", k), 32'(settling_o), 32'h1);
      end else begin
        check($sformatf("d7_valid_%0d", k), 32'(valid_o), 32'h1);
        check($sformatf("d7_data_%0d", k), 32'(data_o), 32'(8'h65 + (k - 7)));
      end
      check($sformatf("d7_cfg_err_%0d", k), 32'(cfg_err_o), 32'h0);
    end

    // Out-of-range request clamps to 15 with a single error pulse.
    for (int k = 0; k < 18; k++) begin
      tick(5'd31, 1'b1, 8'(8'h80 + k));
      check($sformatf("oor_cfg_err_%0d", k), 32'(cfg_err_o), (k == 0) ? 32'h1 : 32'h0);
      if (k == 0) check("oor_dly_q", 32'(dut.u_ctrl.dly_q), 32'd15);
      if (k < 15) begin
        check($sformatf("oor_mask_v_%0d", k), 32'(valid_o), 32'h0);
      end else begin
        check($sformatf("oor_valid_%0d", k), 32'(valid_o), 32'h1);
        check($sformatf("oor_data_%0d", k), 32'(data_o), 32'(8'h80 + (k - 15)));
      end
    end

    // Change to 10, reset at settle cycle 4.
    for (int k = 0; k < 4; k++) begin
      tick(5'd10, 1'b1, 8'(8'hC0 + k));
      check($sformatf("d10_mask_s_%0d", k), 32'(settling_o), 32'h1);
    end
    rst_i = 1'b0;
    tick(5'd10, 1'b1, 8'hCC);
    check("mid_rst_data", 32'(data_o), 32'h0);
    check("mid_rst_valid", 32'(valid_o), 32'h0);
    check("mid_rst_settling", 32'(settling_o), 32'h0);
    check("mid_rst_cfg_err", 32'(cfg_err_o), 32'h0);
    check("mid_rst_dly_q", 32'(dut.u_ctrl.dly_q), 32'h0);
    check("mid_rst_state", 32'(dut.u_ctrl.state_q), 32'(RUN));
    rst_i = 1'b1;
    for (int k = 0; k < 13; k++) begin
      tick(5'd10, 1'b1, 8'(8'h90 + k));
      if (k == 0) check("rel_dly_q", 32'(dut.u_ctrl.dly_q), 32'd10);
      if (k < 10) begin
        check($sformatf("rel_mask_v_%0d", k), 32'(valid_o), 32'h0);
        check($sformatf("rel_mask_s_%0d", k), 32'(settling_o), 32'h1);
      end else begin
        check($sformatf("rel_valid_%0d", k), 32'(valid_o), 32'h1);
        check($sformatf("rel_data_%0d", k), 32'(data_o), 32'(8'h90 + (k - 10)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
